lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
// - Memory-access stage directly downstream of the address-generation unit (AGU).
// - Takes one load/store request (effective address, op, size, signedness, store data, dest tag).
// - Drives the dcache request/response handshake.
// - Aligns and extends load data, then returns a writeback result to the pipeline.
// - Single outstanding request; flushable; optional misaligned-address exception.
// PARAMETERS
// - RD_W    5   width of destination register tag carried through
// - ADDR_W  32  effective address width
// PORTS
// - clk          in   1       clock, all state on rising edge
// - reset        in   1       asynchronous, active-high reset
// - flush        in   1       kill in-flight op (pipeline redirect)
// - in_valid     in   1       AGU request valid
// - in_ready     out  1       stage can accept request
// - in_op        in   1       0 = load, 1 = store
// - in_addr      in   ADDR_W  effective address from AGU
// - in_size      in   2       0 = byte, 1 = half, 2 = word (3 is treated as word)
// - in_unsigned  in   1       load zero-extends when 1
// - in_wdata     in   32      store data, right-justified
// - in_rd        in   RD_W    destination register tag
// - dc_valid     out  1       dcache request valid
// - dc_ready     in   1       dcache accepts request this cycle
// - dc_op        out  1       0 = read, 1 = write
// - dc_addr      out  ADDR_W  request address
// - dc_wstrb     out  4       byte-lane write strobe
// - dc_wdata     out  32      lane-replicated store data
// - dc_rvalid    in   1       read data valid (one pulse per accepted read)
// - dc_rdata     in   32      read word
// - out_valid    out  1       result valid
// - out_ready    in   1       consumer accepts result
// - out_we       out  1       result writes register (loads only)
// - out_rd       out  RD_W    destination tag
// - out_data     out  32      aligned, extended load data; 0 for stores
// - out_ale      out  1       misaligned-address exception
// BEHAVIOUR
// - Reset: state IDLE.
//   - dc_valid, out_valid, out_we, out_ale = 0; all data/tag regs = 0; in_ready = 1.
// - FSM: IDLE, REQ, WAIT, RESP, DRAIN. Outputs are decoded from state and registers.
// - IDLE: in_ready = 1. When in_valid & ~flush, latch the request.
//   - Transition to REQ (or RESP on ALE, if enabled).
// - REQ: dc_valid = 1 and dc_* held stable until dc_ready.
//   - On dc_ready with store: go to RESP; out_we = 0, out_data = 0.
//   - On dc_ready with load: go to WAIT.
// - WAIT: on dc_rvalid, capture the aligned result; go to RESP.
// - RESP: out_valid = 1 until out_ready, then IDLE.
//   - No new accept in the same cycle; minimum 1 idle cycle between ops.
// - Store lanes, with a = addr[1:0]:
//   - byte: wstrb = 4'b0001 << a, wdata = {4{d[7:0]}}.
//   - half: wstrb = a[1] ? 4'b1100 : 4'b0011, wdata = {2{d[15:0]}}.
//   - word: wstrb = 4'b1111.
// - Load align:
//   - byte: rdata[8a+7:8a].
//   - half: rdata[16*a[1]+15 : 16*a[1]].
//   - Sign-extend unless in_unsigned; word passes through.
// - dc_addr = latched address unmodified.
// - Flush:
//   - IDLE: in_valid ignored.
//   - REQ before dc_ready: drop, go to IDLE, no cache access.
//   - REQ same cycle as dc_ready: treated as accepted. A store is committed; the op is then discarded (IDLE if store, DRAIN if load).
//   - WAIT: go to DRAIN, wait for dc_rvalid, discard data, then IDLE.
//   - DRAIN ignores flush.
//   - RESP: drop out_valid, go to IDLE.
//   - in_ready = 0 in DRAIN.
// - dc_rvalid outside WAIT/DRAIN is ignored.
// - Async reset mid-operation returns to IDLE immediately; any outstanding dcache read is the cache's responsibility to squash.
// - Latency (zero-wait cache, out_ready = 1): store 3 cycles accept -> out_valid; load 4 cycles.
// CONFIGURATION
// - Macro LSU_MEM_ALE_CHECK_EN.
// - Defined: half with addr[0] = 1, or word with addr[1:0] != 0, raises ALE.
//   - No dcache request; IDLE -> RESP directly.
//   - out_ale = 1, out_we = 0, out_data = 0.
// - Undefined: out_ale tied 0. Half ignores addr[0]; word ignores addr[1:0] for lane select. Request always issued.
// TESTING
// - Load byte signed: addr 0x1003, rdata 0x80AA_BBCC -> out_data 0xFFFF_FF80, out_we = 1, 4 cycles.
// - Store half: addr 0x2002, wdata 0x0000_1234 -> dc_wstrb 1100, dc_wdata 0x1234_1234, dc_op = 1.
// - dc_ready held low 5 cycles: dc_addr/dc_wstrb stable; out_ready low 3 cycles: out_data held.
// - Flush in WAIT: dc_rvalid 2 cycles later -> no out_valid, in_ready low until rvalid, then 1.
// - LSU_MEM_ALE_CHECK_EN: word load at 0x3002 -> out_ale = 1, dc_valid never asserted; undefined: dc_valid = 1.
// - Reset asserted in REQ -> dc_valid = 0 same cycle, in_ready = 1 after release.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: drives the dcache handshake and aligns load data.
// Optional misaligned-address exception enabled by LSU_MEM_ALE_CHECK_EN.
module lsu_mem_stage #(
  parameter int RD_W   = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  output logic              dc_valid,
  input  logic              dc_ready,
  output logic              dc_op,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [3:0]        dc_wstrb,
  output logic [31:0]       dc_wdata,
  input  logic              dc_rvalid,
  input  logic [31:0]       dc_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [RD_W-1:0]   out_rd,
  output logic [31:0]       out_data,
  output logic              out_ale
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, RESP, DRAIN
  } state_t;

  state_t     state;
  logic [1:0] size_q;
  logic       uns_q;
  logic       mis;

  function automatic logic [3:0] strb_f(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    case (sz)
      2'd0:    strb_f = 4'b0001 << a;
      2'd1:    strb_f = a[1] ? 4'b1100 : 4'b0011;
      default: strb_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdat_f(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    case (sz)
      2'd0:    wdat_f = {4{d[7:0]}};
      2'd1:    wdat_f = {2{d[15:0]}};
      default: wdat_f = d;
    endcase
  endfunction

  function automatic logic [31:0] load_f(
    input logic [1:0]  sz,
    input logic [1:0]  a,
    input logic        uns,
    input logic [31:0] r
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(r >> {a, 3'b000});
    h = 16'(r >> {a[1], 4'b0000});
    case (sz)
      2'd0:    load_f = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    load_f = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_f = r;
    endcase
  endfunction

`ifdef LSU_MEM_ALE_CHECK_EN
  assign mis = (in_size == 2'd1 && in_addr[0]) ||
               (in_size[1] && in_addr[1:0] != 2'd0);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      size_q    <= '0;
      uns_q     <= 1'b0;
      in_ready  <= 1'b1;
      dc_valid  <= 1'b0;
      dc_op     <= 1'b0;
      dc_addr   <= '0;
      dc_wstrb  <= '0;
      dc_wdata  <= '0;
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
      out_ale   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            size_q   <= in_size;
            uns_q    <= in_unsigned;
            dc_op    <= in_op;
            dc_addr  <= in_addr;
            dc_wstrb <= in_op ? strb_f(in_size, in_addr[1:0]) : 4'b0000;
            dc_wdata <= wdat_f(in_size, in_wdata);
            out_rd   <= in_rd;
            out_we   <= 1'b0;
            out_data <= '0;
            out_ale  <= mis;
            in_ready <= 1'b0;
            if (mis) begin
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              dc_valid <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (dc_ready) begin
            dc_valid <= 1'b0;
            // An accepted store is committed even when flushed.
            if (flush && dc_op) begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end else if (flush) begin
              state <= DRAIN;
            end else if (dc_op) begin
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= WAIT;
            end
          end else if (flush) begin
            dc_valid <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        WAIT: begin
          if (flush) begin
            if (dc_rvalid) begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (dc_rvalid) begin
            out_data  <= load_f(size_q, dc_addr[1:0], uns_q, dc_rdata);
            out_we    <= 1'b1;
            out_valid <= 1'b1;
            state     <= RESP;
          end
        end
        DRAIN: begin
          if (dc_rvalid) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        RESP: begin
          if (out_ready || flush) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          dc_valid  <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed vectors, dcache model,
// result monitor decoupled from stimulus.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_op = 1'b0;
  logic [31:0] in_addr = '0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic [31:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        dc_ready = 1'b0;
  logic        dc_rvalid = 1'b0;
  logic [31:0] dc_rdata = '0;
  logic        out_ready = 1'b1;

  logic        in_ready;
  logic        dc_valid;
  logic        dc_op;
  logic [31:0] dc_addr;
  logic [3:0]  dc_wstrb;
  logic [31:0] dc_wdata;
  logic        out_valid;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_ale;

  lsu_mem_stage #(.RD_W(5), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_wdata(in_wdata), .in_rd(in_rd),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_op(dc_op),
    .dc_addr(dc_addr), .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
    .out_rd(out_rd), .out_data(out_data), .out_ale(out_ale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [38:0] v;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [68:0] dcq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  int          ready_stall = 0;
  int          rv_delay = 0;
  int          out_stall = 0;
  logic [31:0] rd_word = '0;

  int          c_stall = 0;
  int          c_rv = 0;
  bit          c_inreq = 0;
  bit          c_accrd = 0;
  logic [68:0] c_held = '0;
  logic [68:0] c_exp = '0;
  int          m_ost = 0;
  bit          m_prev = 0;
  logic [31:0] m_hold = '0;
  exp_t        m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [68:0] act,
                     input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_out(input bit ale, input bit we,
                          input logic [4:0] rd, input logic [31:0] d,
                          input int lat);
    exp_t e;
    e.v   = {ale, we, rd, d};
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic push_dc(input bit op, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    dcq.push_back({op, a, s, d});
  endtask

  task automatic issue(input bit op, input logic [31:0] a,
                       input logic [1:0] sz, input bit uns,
                       input logic [31:0] wd, input logic [4:0] rd);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("issue_timeout", 69'(1), 69'(0));
    in_op       = op;
    in_addr     = a;
    in_size     = sz;
    in_unsigned = uns;
    in_wdata    = wd;
    in_rd       = rd;
    in_valid    = 1'b1;
    acc_cyc     = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((sb.size() != 0 || dcq.size() != 0 || !in_ready) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) chk("settle_timeout", 69'(1), 69'(0));
  endtask

  // dcache model: stalls ready, returns read data after rv_delay.
  initial forever begin
    @(negedge clk);
    dc_rvalid = 1'b0;
    if (c_rv > 0) begin
      c_rv--;
      if (c_rv == 0) begin
        dc_rvalid = 1'b1;
        dc_rdata  = rd_word;
      end
    end
    if (c_accrd) begin
      c_accrd = 0;
      if (rv_delay == 0) begin
        dc_rvalid = 1'b1;
        dc_rdata  = rd_word;
      end else begin
        c_rv = rv_delay;
      end
    end
    if (dc_valid) begin
      if (!c_inreq) begin
        c_inreq = 1;
        c_held  = {dc_op, dc_addr, dc_wstrb, dc_wdata};
      end else begin
        chk("dc_stable", {dc_op, dc_addr, dc_wstrb, dc_wdata}, c_held);
      end
      if (c_stall < ready_stall) begin
        dc_ready = 1'b0;
        c_stall++;
      end else begin
        dc_ready = 1'b1;
        c_stall  = 0;
        c_inreq  = 0;
        if (dcq.size() == 0) begin
          chk("dc_unexpected", 69'(1), 69'(0));
        end else begin
          c_exp = dcq.pop_front();
          chk("dc_req", {dc_op, dc_addr, dc_wstrb, dc_wdata}, c_exp);
        end
        if (!dc_op) c_accrd = 1;
      end
    end else begin
      dc_ready = 1'b0;
      c_stall  = 0;
      c_inreq  = 0;
    end
  end

  // Result monitor: latency on first valid, hold while stalled, pop on accept.
  initial forever begin
    @(negedge clk);
    if (!out_valid) begin
      m_ost     = 0;
      m_prev    = 0;
      out_ready = 1'b1;
    end else begin
      if (!m_prev) begin
        m_prev = 1;
        m_hold = out_data;
        if (sb.size() == 0)
          chk("out_unexpected", 69'(1), 69'(0));
        else if (sb[0].lat != 0)
          chk("latency", 69'(cyc - acc_cyc + 1), 69'(sb[0].lat));
      end else begin
        chk("out_hold", 69'(out_data), 69'(m_hold));
      end
      if (m_ost < out_stall) begin
        out_ready = 1'b0;
        m_ost++;
      end else begin
        out_ready = 1'b1;
        if (sb.size() > 0) begin
          m_e = sb.pop_front();
          chk("out_result", 69'({out_ale, out_we, out_rd, out_data}),
              69'(m_e.v));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 69'({in_ready, dc_valid, out_valid, out_we, out_ale}),
        69'(5'b10000));
    chk("rst_data", 69'({out_data, dc_addr}), 69'(0));
    chk("rst_lanes", 69'({dc_wstrb, dc_wdata, out_rd, dc_op}), 69'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    rd_word = 32'h80AA_BBCC;
    push_dc(0, 32'h1003, 4'b0000, 32'h0);
    push_out(0, 1, 5'd3, 32'hFFFF_FF80, 4);
    issue(0, 32'h1003, 2'd0, 0, 32'h0, 5'd3);
    settle();

    push_dc(1, 32'h2002, 4'b1100, 32'h1234_1234);
    push_out(0, 0, 5'd4, 32'h0, 3);
    issue(1, 32'h2002, 2'd1, 0, 32'h0000_1234, 5'd4);
    settle();

    push_dc(1, 32'h1001, 4'b0010, 32'hA5A5_A5A5);
    push_out(0, 0, 5'd5, 32'h0, 3);
    issue(1, 32'h1001, 2'd0, 0, 32'h0000_00A5, 5'd5);
    settle();

    push_dc(1, 32'h1000, 4'b1111, 32'hDEAD_BEEF);
    push_out(0, 0, 5'd6, 32'h0, 3);
    issue(1, 32'h1000, 2'd2, 0, 32'hDEAD_BEEF, 5'd6);
    settle();

    rd_word = 32'h8001_7FFF;
    push_dc(0, 32'h2002, 4'b0000, 32'h0);
    push_out(0, 1, 5'd7, 32'h0000_8001, 4);
    issue(0, 32'h2002, 2'd1, 1, 32'h0, 5'd7);
    settle();

    rd_word = 32'h1234_F00D;
    push_dc(0, 32'h2000, 4'b0000, 32'h0);
    push_out(0, 1, 5'd8, 32'hFFFF_F00D, 4);
    issue(0, 32'h2000, 2'd1, 0, 32'h0, 5'd8);
    settle();

    rd_word = 32'h1122_9344;
    push_dc(0, 32'h1001, 4'b0000, 32'h0);
    push_out(0, 1, 5'd9, 32'h0000_0093, 4);
    issue(0, 32'h1001, 2'd0, 1, 32'h0, 5'd9);
    settle();

    rd_word = 32'hCAFE_F00D;
    push_dc(0, 32'h4000, 4'b0000, 32'h0);
    push_out(0, 1, 5'd10, 32'hCAFE_F00D, 4);
    issue(0, 32'h4000, 2'd3, 0, 32'h0, 5'd10);
    settle();

    ready_stall = 5;
    out_stall   = 3;
    rd_word     = 32'h0BAD_F00D;
    push_dc(0, 32'h5000, 4'b0000, 32'h0);
    push_out(0, 1, 5'd11, 32'h0BAD_F00D, 0);
    issue(0, 32'h5000, 2'd2, 0, 32'h0, 5'd11);
    settle();
    out_stall = 0;

    issue(1, 32'h6000, 2'd2, 0, 32'h55, 5'd12);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_req", 69'({dc_valid, in_ready}), 69'(2'b01));
    ready_stall = 0;
    settle();

    push_dc(1, 32'h6004, 4'b1111, 32'h0102_0304);
    issue(1, 32'h6004, 2'd2, 0, 32'h0102_0304, 5'd13);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_req_acc", 69'({dc_valid, out_valid, in_ready}), 69'(3'b001));
    settle();

    rv_delay = 2;
    rd_word  = 32'h7777_7777;
    push_dc(0, 32'h7000, 4'b0000, 32'h0);
    issue(0, 32'h7000, 2'd2, 0, 32'h0, 5'd14);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("drain_busy0", 69'(in_ready), 69'(0));
    @(posedge clk); #1;
    chk("drain_busy1", 69'(in_ready), 69'(0));
    @(posedge clk); #1;
    chk("drain_done", 69'(in_ready), 69'(1));
    rv_delay = 0;
    settle();

    out_stall = 100;
    rd_word   = 32'h0000_0001;
    push_dc(0, 32'h7004, 4'b0000, 32'h0);
    push_out(0, 1, 5'd15, 32'h0000_0001, 0);
    issue(0, 32'h7004, 2'd2, 0, 32'h0, 5'd15);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_seen", 69'(out_valid), 69'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_resp", 69'({out_valid, in_ready}), 69'(2'b01));
    sb.delete();
    out_stall = 0;
    settle();

    rd_word = 32'h1122_3344;
`ifdef LSU_MEM_ALE_CHECK_EN
    push_out(1, 0, 5'd16, 32'h0, 0);
    issue(0, 32'h3002, 2'd2, 0, 32'h0, 5'd16);
    chk("ale_no_dc", 69'(dc_valid), 69'(0));
`else
    push_dc(0, 32'h3002, 4'b0000, 32'h0);
    push_out(0, 1, 5'd16, 32'h1122_3344, 4);
    issue(0, 32'h3002, 2'd2, 0, 32'h0, 5'd16);
    chk("ale_off_dc", 69'(dc_valid), 69'(1));
`endif
    settle();

    ready_stall = 5;
    issue(0, 32'h8000, 2'd2, 0, 32'h0, 5'd17);
    chk("req_before_rst", 69'(dc_valid), 69'(1));
    reset = 1'b1;
    #1;
    chk("rst_req", 69'({dc_valid, out_valid}), 69'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_release", 69'(in_ready), 69'(1));
    ready_stall = 0;
    @(posedge clk); #1;

    rd_word = 32'h0000_0080;
    push_dc(0, 32'h9000, 4'b0000, 32'h0);
    push_out(0, 1, 5'd18, 32'hFFFF_FF80, 4);
    issue(0, 32'h9000, 2'd0, 0, 32'h0, 5'd18);
    settle();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
